vx_ifetch_rsp_queue: RTL and testbench



---
 rtl/vx_ifetch_rsp_queue.sv | 134 +++++++++++++
 tb/tb_vx_ifetch_rsp_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ifetch_rsp_queue.sv
// vx_ifetch_rsp_queue
// -------------------
// In-order decoupling FIFO between the icache fetch-response output and the
// decode stage. Each entry carries warp ID, thread mask, PC and instruction
// word. All outputs are driven from registered state. in_ready additionally
// depends on flush and on the reset input. It never depends on out_ready.
//
// Optional feature (macro IFETCH_RSP_QUEUE_PERF_EN):
//   adds perf_stall_cycles, a 64-bit count of cycles in which a response was
//   offered (in_valid) but refused (!in_ready) while out of reset. Only reset
//   clears it; flush does not.
//
// Ports:
//   clk                 core clock, all state updates on the rising edge
//   reset               synchronous, active-low reset
//   flush               discard every entry; any push/pop this cycle is ignored
//   in_valid/in_ready   fetch-response handshake (push side)
//   in_wid, in_tmask, in_PC, in_instr   entry fields to enqueue
//   out_valid/out_ready decode handshake (pop side)
//   out_wid, out_tmask, out_PC, out_instr  head entry fields (valid with out_valid)
//   count               number of occupied entries (0..DEPTH)
//   busy                count != 0
//   perf_stall_cycles   refused-offer cycle count (perf build only)
//
// Handshake semantics (both sides): a transfer happens at a rising edge
// exactly when valid && ready are both high in the preceding cycle. A source
// holds valid and its payload stable until the transfer. During a flush cycle
// neither side transfers. out_valid may still be high, but decode must treat
// that handshake as void.
module vx_ifetch_rsp_queue #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int DEPTH       = 4,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NW_BITS-1:0]     in_wid,
  input  logic [NUM_THREADS-1:0] in_tmask,
  input  logic [31:0]            in_PC,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NW_BITS-1:0]     out_wid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [31:0]            out_PC,
  output logic [31:0]            out_instr,
  output logic [PTR_W:0]         count,
  output logic                   busy
`ifdef IFETCH_RSP_QUEUE_PERF_EN
  ,
  output logic [63:0]            perf_stall_cycles
`endif
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // Storage is deliberately not reset; count gates validity.
  logic [NW_BITS-1:0]     wid_mem   [DEPTH];
  logic [NUM_THREADS-1:0] tmask_mem [DEPTH];
  logic [31:0]            pc_mem    [DEPTH];
  logic [31:0]            instr_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_q;

  logic push;
  logic pop;

  // A slot freed by a pop only becomes visible next cycle, because in_ready
  // looks at the registered count and not at out_ready.
  assign in_ready  = reset && (count_q < FULL_COUNT) && !flush;
  assign out_valid = (count_q != '0);
  assign busy      = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !flush && reset;

  assign out_wid   = wid_mem[rd_ptr];
  assign out_tmask = tmask_mem[rd_ptr];
  assign out_PC    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      wid_mem[wr_ptr]   <= in_wid;
      tmask_mem[wr_ptr] <= in_tmask;
      pc_mem[wr_ptr]    <= in_PC;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

`ifdef IFETCH_RSP_QUEUE_PERF_EN
  logic [63:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready) begin
      stall_cnt <= stall_cnt + 64'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_vx_ifetch_rsp_queue.sv
// Testbench for vx_ifetch_rsp_queue (DEPTH=4, 4 warps, 4 threads).
// Directed scenarios; the driver pushes expected entries into exp_q when it
// issues them, and a negedge monitor pops and compares on every modelled
// dequeue, and checks count/busy/out_valid/in_ready against a bench model.
module tb_vx_ifetch_rsp_queue;
  localparam int NW    = 2;
  localparam int NT    = 4;
  localparam int DEPTH = 4;
  localparam int EW    = NW + NT + 64;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_wid;
  logic [NT-1:0] in_tmask;
  logic [31:0]   in_PC;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_wid;
  logic [NT-1:0] out_tmask;
  logic [31:0]   out_PC;
  logic [31:0]   out_instr;
  logic [2:0]    count;
  logic          busy;
`ifdef IFETCH_RSP_QUEUE_PERF_EN
  logic [63:0]   perf_stall_cycles;
`endif

  vx_ifetch_rsp_queue #(
    .NUM_WARPS(4), .NUM_THREADS(NT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC), .out_instr(out_instr),
    .count(count), .busy(busy)
`ifdef IFETCH_RSP_QUEUE_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          mon_en = 1'b0;
  int            m_count = 0;
  logic          m_push = 1'b0;
  logic [63:0]   m_perf = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic          exp_rdy;
    logic          m_pop;
    logic [EW-1:0] e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      exp_rdy = reset && (m_count < DEPTH) && !flush;
      chk("count", 64'(count), 64'(m_count));
      chk("busy", 64'(busy), 64'(m_count != 0));
      chk("out_valid", 64'(out_valid), 64'(m_count != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
`ifdef IFETCH_RSP_QUEUE_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, m_perf);
`endif
      m_push = in_valid && exp_rdy;
      m_pop  = reset && !flush && (m_count != 0) && out_ready;
      if (m_pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got PC 0x%0h expected no entry", out_PC);
        end else begin
          e = exp_q.pop_front();
          chk("out_wid", 64'(out_wid), 64'(e[EW-1 -: NW]));
          chk("out_tmask", 64'(out_tmask), 64'(e[63+NT -: NT]));
          chk("out_PC", 64'(out_PC), 64'(e[63:32]));
          chk("out_instr", 64'(out_instr), 64'(e[31:0]));
        end
      end
      if (!reset) m_perf = '0;
      else if (in_valid && !exp_rdy) m_perf = m_perf + 64'd1;
      if (!reset || flush) begin
        m_count = 0;
        exp_q.delete();
      end else begin
        m_count = m_count + int'(m_push) - int'(m_pop);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_entry(input logic [NW-1:0] w, input logic [NT-1:0] t,
                            input logic [31:0] pc, input logic [31:0] ins);
    int waited = 0;
    in_valid = 1'b1;
    in_wid   = w;
    in_tmask = t;
    in_PC    = pc;
    in_instr = ins;
    exp_q.push_back({w, t, pc, ins});
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!m_push && waited < 50);
    if (!m_push) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: PC 0x%0h not accepted after %0d cycles", pc, waited);
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int waited = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 50) begin
      cycles(1);
      waited++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    cycles(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] perf_base;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_wid = '0; in_tmask = '0; in_PC = '0; in_instr = '0;
    perf_base = '0;
    cycles(2);
    mon_en = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // Single push with decode ready: visible one cycle, then gone.
    out_ready = 1'b1;
    push_entry(2'd1, 4'b1011, 32'h8000_0000, 32'h0000_0013);
    chk("single_count1", 64'(count), 64'd1);
    chk("single_valid", 64'(out_valid), 64'd1);
    cycles(1);
    chk("single_count0", 64'(count), 64'd0);

    // Fill and drain: fifth entry held while full, accepted after first pop.
    out_ready = 1'b0;
    fork
      begin
        push_entry(2'd0, 4'b0001, 32'h100, 32'h1111_0001);
        push_entry(2'd1, 4'b0010, 32'h104, 32'h1111_0002);
        push_entry(2'd2, 4'b0100, 32'h108, 32'h1111_0003);
        push_entry(2'd3, 4'b1000, 32'h10C, 32'h1111_0004);
        push_entry(2'd0, 4'b1111, 32'h110, 32'h1111_0005);
      end
      begin
        cycles(7);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cycles(1);
        chk("after_pop_count", 64'(count), 64'd3);
        chk("after_pop_in_ready", 64'(in_ready), 64'd1);
      end
    join
    drain();

    // Streaming: push and pop every cycle; pointers wrap several times.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_entry(2'(i), 4'(i + 1), 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      chk("stream_count", 64'(count), 64'd1);
    end
    drain();

    // Flush with a concurrent push and pop offer: neither takes effect.
    out_ready = 1'b0;
    push_entry(2'd2, 4'b0110, 32'h300, 32'hB000_0000);
    push_entry(2'd3, 4'b0111, 32'h304, 32'hB000_0001);
    push_entry(2'd0, 4'b1001, 32'h308, 32'hB000_0002);
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_wid = 2'd1; in_tmask = 4'b1100; in_PC = 32'h30C; in_instr = 32'hB000_0003;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    cycles(2);
    // Entries after a flush start from a clean queue.
    push_entry(2'd1, 4'b0011, 32'h400, 32'hC000_0000);
    drain();

    // Reset mid-operation with two entries queued.
    out_ready = 1'b0;
    push_entry(2'd1, 4'b0001, 32'h500, 32'hD000_0000);
    push_entry(2'd2, 4'b0010, 32'h504, 32'hD000_0001);
    chk("pre_reset_count", 64'(count), 64'd2);
    reset = 1'b0;
    cycles(1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_release_in_ready", 64'(in_ready), 64'd1);
    cycles(1);

    // Stall counting: full queue, offer held for 7 cycles, then flush.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_entry(2'(i), 4'b1111, 32'h600 + 32'(4 * i), 32'hE000_0000 + 32'(i));
    end
`ifdef IFETCH_RSP_QUEUE_PERF_EN
    perf_base = perf_stall_cycles;
`endif
    in_valid = 1'b1; in_wid = 2'd3; in_tmask = 4'b0101;
    in_PC = 32'h700; in_instr = 32'hF000_0000;
    cycles(7);
    in_valid = 1'b0;
`ifdef IFETCH_RSP_QUEUE_PERF_EN
    chk("perf_delta7", perf_stall_cycles - perf_base, 64'd7);
`endif
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    chk("perf_flush_count", 64'(count), 64'd0);
`ifdef IFETCH_RSP_QUEUE_PERF_EN
    chk("perf_kept_after_flush", perf_stall_cycles - perf_base, 64'd7);
`endif
    cycles(2);

    chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end
endmodule
